// File: rtl/input_ports.sv
// rtl/input_ports.sv - memory-mapped input ports with synchronizers and change flags
module input_ports #(
  parameter logic [7:0] BASE_ADDR   = 8'hE0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       read,
  input  logic [7:0] port_in_00,
  input  logic [7:0] port_in_01,
  input  logic [7:0] port_in_02,
  input  logic [7:0] port_in_03,
  input  logic [7:0] port_in_04,
  input  logic [7:0] port_in_05,
  input  logic [7:0] port_in_06,
  input  logic [7:0] port_in_07,
  input  logic [7:0] port_in_08,
  input  logic [7:0] port_in_09,
  input  logic [7:0] port_in_10,
  input  logic [7:0] port_in_11,
  input  logic [7:0] port_in_12,
  input  logic [7:0] port_in_13,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       change_irq
);

  localparam int         NP        = 14;
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [NP-1:0][7:0]                  port_in;
  logic [SYNC_STAGES-1:0][NP-1:0][7:0] sync_q, sync_d;
  logic [NP-1:0][7:0]                  sync_last;
  logic [NP-1:0][7:0]                  prev_q, prev_d;
  logic [2:0]                          prime_q, prime_d;
  logic [NP-1:0]                       flags_q, flags_d;
  logic [NP-1:0]                       set_mask, clr_mask;
  logic [7:0]                          data_out_q, data_out_d;
  logic                                data_valid_q, data_valid_d;
  logic                                primed;
  logic                                hit;
  logic [3:0]                          offset;

  assign port_in = {port_in_13, port_in_12, port_in_11, port_in_10, port_in_09,
                    port_in_08, port_in_07, port_in_06, port_in_05, port_in_04,
                    port_in_03, port_in_02, port_in_01, port_in_00};

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign primed    = (prime_q == PRIME_MAX);
  assign hit       = read && (address[7:4] == BASE_ADDR[7:4]);
  assign offset    = address[3:0];

  always_comb begin
    sync_d[0] = port_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d  = sync_last;
    prime_d = primed ? prime_q : prime_q + 3'd1;

    // Detection stays off until the sync chain and prev registers hold real input levels.
    set_mask = '0;
    for (int i = 0; i < NP; i++) begin
      set_mask[i] = primed && (sync_last[i] != prev_q[i]);
    end

    data_out_d   = data_out_q;
    data_valid_d = hit;
    clr_mask     = '0;
    if (hit) begin
      case (offset)
        4'hE: begin
          data_out_d    = flags_q[7:0];
          clr_mask[7:0] = '1;
        end
        4'hF: begin
          data_out_d     = {2'b00, flags_q[13:8]};
          clr_mask[13:8] = '1;
        end
        default: data_out_d = sync_last[offset];
      endcase
    end

    // A set on the clearing edge wins so no change event is lost.
    flags_d = (flags_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= '0;
      prev_q       <= '0;
      prime_q      <= '0;
      flags_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      prime_q      <= prime_d;
      flags_q      <= flags_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign change_irq = |flags_q;

endmodule

// File: tb/tb_input_ports.sv
// tb/tb_input_ports.sv - directed self-checking bench for input_ports
module tb_input_ports;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic       read;
  logic [7:0] pin [14];
  logic [7:0] data_out;
  logic       data_valid;
  logic       change_irq;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  input_ports #(.BASE_ADDR(8'hE0), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (read),
    .port_in_00 (pin[0]),
    .port_in_01 (pin[1]),
    .port_in_02 (pin[2]),
    .port_in_03 (pin[3]),
    .port_in_04 (pin[4]),
    .port_in_05 (pin[5]),
    .port_in_06 (pin[6]),
    .port_in_07 (pin[7]),
    .port_in_08 (pin[8]),
    .port_in_09 (pin[9]),
    .port_in_10 (pin[10]),
    .port_in_11 (pin[11]),
    .port_in_12 (pin[12]),
    .port_in_13 (pin[13]),
    .data_out   (data_out),
    .data_valid (data_valid),
    .change_irq (change_irq)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    read    = 1'b1;
    address = addr;
    step();
    check({tag, "_dv"}, {7'd0, data_valid}, 8'h01);
    check({tag, "_data"}, data_out, exp);
    read    = 1'b0;
    address = 8'h00;
  endtask

  initial begin
    reset   = 1'b0;
    read    = 1'b0;
    address = 8'h00;
    for (int i = 0; i < 14; i++) pin[i] = 8'h00;
    pin[3] = 8'h5A;

    // Reset then prime
    step();
    step();
    check("rst_data", data_out, 8'h00);
    check("rst_dv", {7'd0, data_valid}, 8'h00);
    check("rst_irq", {7'd0, change_irq}, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("prime_irq", {7'd0, change_irq}, 8'h00);
    end
    rd(8'hE3, 8'h5A, "prime_rd_e3");
    step();
    check("prime_dv_drop", {7'd0, data_valid}, 8'h00);
    check("prime_hold", data_out, 8'h5A);
    rd(8'hEE, 8'h00, "prime_flags_lo");
    rd(8'hEF, 8'h00, "prime_flags_hi");

    // Sync latency: change before edge n, flag visible after edge n+2
    pin[0] = 8'h81;
    step();
    check("lat_n", {7'd0, change_irq}, 8'h00);
    step();
    check("lat_n1", {7'd0, change_irq}, 8'h00);
    step();
    check("lat_n2", {7'd0, change_irq}, 8'h01);
    rd(8'hE0, 8'h81, "lat_rd_e0");
    rd(8'hEE, 8'h01, "lat_flags");
    check("lat_irq_clr", {7'd0, change_irq}, 8'h00);

    // Read-to-clear across both status registers
    pin[1] = 8'h11;
    pin[9] = 8'h22;
    repeat (3) step();
    check("rtc_irq", {7'd0, change_irq}, 8'h01);
    rd(8'hEE, 8'h02, "rtc_ee");
    check("rtc_irq_mid", {7'd0, change_irq}, 8'h01);
    rd(8'hEF, 8'h02, "rtc_ef");
    check("rtc_irq_off", {7'd0, change_irq}, 8'h00);
    rd(8'hEE, 8'h00, "rtc_ee2");
    rd(8'hEF, 8'h00, "rtc_ef2");

    // Set wins over a simultaneous read-clear
    pin[2] = 8'h0F;
    repeat (3) step();
    check("sw_irq", {7'd0, change_irq}, 8'h01);
    pin[2] = 8'hF0;
    step();
    step();
    rd(8'hEE, 8'h04, "sw_ee");
    check("sw_irq_kept", {7'd0, change_irq}, 8'h01);
    rd(8'hEE, 8'h04, "sw_ee_again");
    check("sw_irq_off", {7'd0, change_irq}, 8'h00);

    // Address window edges and back-to-back reads
    pin[4]  = 8'h44;
    pin[5]  = 8'h5C;
    pin[6]  = 8'h6D;
    pin[13] = 8'hD3;
    repeat (3) step();
    read = 1'b1;
    address = 8'hDF;
    step();
    check("win_df_dv", {7'd0, data_valid}, 8'h00);
    check("win_df_hold", data_out, 8'h04);
    address = 8'hE5;
    step();
    check("win_e5_dv", {7'd0, data_valid}, 8'h01);
    check("win_e5_data", data_out, 8'h5C);
    address = 8'hE6;
    step();
    check("win_e6_dv", {7'd0, data_valid}, 8'h01);
    check("win_e6_data", data_out, 8'h6D);
    address = 8'hF0;
    step();
    check("win_f0_dv", {7'd0, data_valid}, 8'h00);
    check("win_f0_hold", data_out, 8'h6D);
    read = 1'b0;
    rd(8'hED, 8'hD3, "win_ed");
    rd(8'hEE, 8'h70, "win_flags_lo");
    rd(8'hEF, 8'h20, "win_flags_hi");

    // Reset during a read
    pin[7] = 8'h77;
    repeat (3) step();
    check("mr_irq_pre", {7'd0, change_irq}, 8'h01);
    reset   = 1'b0;
    read    = 1'b1;
    address = 8'hE4;
    step();
    check("mr_dv", {7'd0, data_valid}, 8'h00);
    check("mr_data", data_out, 8'h00);
    check("mr_irq", {7'd0, change_irq}, 8'h00);
    reset   = 1'b1;
    read    = 1'b0;
    address = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mr_prime_irq", {7'd0, change_irq}, 8'h00);
    end
    rd(8'hE4, 8'h44, "mr_rd_e4");
    rd(8'hEE, 8'h00, "mr_flags_lo");
    rd(8'hEF, 8'h00, "mr_flags_hi");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/input_ports.md
Name: input_ports

Overview:
- Memory-mapped input port block for the 8-bit CPU. It is the read-side counterpart of the output port latches.
- Decodes CPU reads in the 16-byte window at BASE_ADDR: 14 external 8-bit input ports at offsets 0x0–0xD, and two change-flag status registers at offsets 0xE–0xF.
- Inputs are asynchronous to clk. Each one passes through a synchronizer, then change detection, which raises sticky read-to-clear flags and an interrupt line.

Parameters:
BASE_ADDR, 8'hE0, first address of the 16-byte window (E0..EF); lower 4 bits must be 0
SYNC_STAGES, 2, synchronizer depth per input bit; legal values 2 or 3

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
address  input  8  CPU address bus
read  input  1  CPU read strobe, one cycle per access
port_in_00 .. port_in_13  input  8 each  asynchronous external inputs, ports 0–13
data_out  output  8  read data to CPU
data_valid  output  1  one-cycle pulse: data_out holds the result of the read issued the previous cycle
change_irq  output  1  high while any change flag is set

Behaviour:
- Reset (reset==0 sampled at a rising edge) clears all of the following:
  - synchronizer flops, previous-value registers, flags[13:0]
  - data_out=8'h00, data_valid=0, change_irq=0
  - prime counter=0
- Synchronizer:
  - Each port_in_NN goes through a SYNC_STAGES-deep flop chain; the last stage is sync_NN.
  - prev_NN <= sync_NN every cycle.
- Prime counter:
  - Counts rising edges after reset release, saturating at SYNC_STAGES+1.
  - Change detection is disabled until the counter saturates, so static post-reset input levels never raise flags.
- Change detection (when primed):
  - flags[NN] sets at the edge where sync_NN != prev_NN.
  - Latency: an input stable before edge n sets its flag after edge n+SYNC_STAGES.
- Hit: read==1 and address[7:4]==BASE_ADDR[7:4]; offset = address[3:0].
- Read latency is 1 cycle. On a hit sampled at edge n:
  - data_out and data_valid=1 are visible after edge n.
  - data_valid returns to 0 after edge n+1 unless another hit is sampled.
- Offsets 0x0–0xD: data_out <= sync_NN as sampled at edge n. Reading a data port does not touch its flag.
- Offset 0xE: data_out <= flags[7:0]; those returned bits are cleared at the same edge.
- Offset 0xF: data_out <= {2'b00, flags[13:8]}; those returned bits are cleared at the same edge.
- Simultaneous set and clear of the same flag: set wins, and the flag stays 1. Flags not returned by the read are never cleared.
- Non-hit cycle (read==0 or address outside the window):
  - data_valid <= 0; data_out holds its last value.
  - Writes to the window are ignored; this block has no write port.
- Back-to-back reads every cycle are supported; each produces its own data_valid pulse.
- change_irq = OR of flags[13:0], driven directly from the flag registers. It rises the cycle a flag sets and falls the cycle after the read that clears the last set flag.
- Reset mid-operation:
  - An in-flight read is dropped: data_valid=0 and data_out=00.
  - The prime sequence restarts after reset release.
- Multi-bit input changes in flight may be captured skewed across bits. Software tolerates this; no bus-level handshake exists.

Test Plan:
- Reset then prime:
  - Stimulus: hold port_in_03=8'h5A through reset, release, wait 4 cycles, read E3.
  - Response: data_valid pulses 1 cycle after read, data_out=5A; flags all 0; change_irq=0 throughout.
- Sync latency:
  - Stimulus: after priming, change port_in_00 00->81 before edge n.
  - Response: flags[0]=1 and change_irq=1 after edge n+2 (SYNC_STAGES=2), not earlier; read E0 returns 81.
- Read-to-clear:
  - Stimulus: set flags 1 and 9 by toggling port_in_01 and port_in_09; read EE, then EF.
  - Response: EE returns 02 and change_irq stays 1; EF returns 02; flags then 0, and change_irq falls after the EF read.
- Set-wins collision:
  - Stimulus: flag 2 set; port_in_02 change reaches detection on the same edge as an EE read.
  - Response: EE returns 04; flags[2] remains 1; the next EE read returns 04 again.
- Address window and back-to-back:
  - Stimulus: reads at DF, E5, E6, F0 on consecutive cycles.
  - Response: data_valid sequence 0,1,1,0 one cycle delayed; data_out = sync_05 then sync_06, then holds sync_06.
- Reset mid-read:
  - Stimulus: reset asserted on the edge that samples a read of E4.
  - Response: data_valid=0, data_out=00, flags cleared; no flag sets for 3 cycles after release despite nonzero inputs.
